// File: rtl/ika9958_cpc_pkg.sv
// Shared types and helpers for the CPC (PLA counter) generator.
package ika9958_cpc_pkg;

    localparam int CPC_LO_W = 4;
    localparam int CPC_HI_W = 5;

    typedef enum logic {
        CPC_MODE_GFX = 1'b0,
        CPC_MODE_TXT = 1'b1
    } cpc_mode_e;

    // Registered modulo decode bundle: delayed low field plus the 8/16 cycle decodes.
    typedef struct packed {
        logic [CPC_LO_W-1:0] z;
        logic [7:0]          z_of_m8c;
        logic [3:0]          z_of_m16c;
    } cpc_modulo_t;

    // Pixel cycles per tile for the latched mode.
    function automatic int tile_len(input cpc_mode_e mode, input int gfx_len, input int txt_len);
        return (mode == CPC_MODE_TXT) ? txt_len : gfx_len;
    endfunction

endpackage

// File: rtl/ika9958_cpc_carry_dly.sv
// Variable-tap delay line for the tile carry. tap=0 is a straight bypass,
// tap=d>0 presents the input from d enabled edges ago. clr empties the line.
module ika9958_cpc_carry_dly #(
    parameter int DLY_MAX = 7,
    parameter int DLY_W   = $clog2(DLY_MAX+1)
)(
    input  logic             phiA,
    input  logic             RST_async_n,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    input  logic [DLY_W-1:0] tap,
    output logic             dout
);

    logic [DLY_MAX-1:0] sr;

    // Shift the carry history on enabled edges; a clear drops everything in flight.
    always_ff @(posedge phiA or negedge RST_async_n) begin
        if (!RST_async_n) begin
            sr <= '0;
        end else if (en) begin
            if (clr) begin
                sr <= '0;
            end else begin
                sr <= DLY_MAX'({sr, din});
            end
        end
    end

    // Tap select; the caller guarantees tap never exceeds DLY_MAX.
    always_comb begin
        dout = din;
        if (tap != '0) begin
            dout = sr[tap - 1'b1];
        end
    end

endmodule

// File: rtl/ika9958_cpc_gen.sv
// Split pixel-cycle / tile counter with delayed tile carry and registered
// modulo decodes. Optional line counter: define IKA9958_CPC_LINE_CNT_EN.
// The 8/16-cycle decode map is defined for a 4-bit pixel-cycle field.
module ika9958_cpc_gen
    import ika9958_cpc_pkg::*;
#(
    parameter int LO_W    = CPC_LO_W,
    parameter int HI_W    = CPC_HI_W,
    parameter int GFX_LEN = 16,
    parameter int TXT_LEN = 12,
    parameter int HI_MOD  = 32,
    parameter int LO_LOAD = 0,
    parameter int HI_LOAD = 0,
    parameter int DLY_MAX = 7
`ifdef IKA9958_CPC_LINE_CNT_EN
   ,parameter int LINE_MOD = 262
`endif
)(
    input  logic                         phiA,
    input  logic                         RST_async_n,
    input  logic                         phiL_NCEN,
    input  logic                         line_sync,
    input  logic                         mode_txt,
    input  logic [$clog2(DLY_MAX+1)-1:0] carry_dly,
    output logic [LO_W+HI_W-1:0]         cpc,
    output logic [LO_W-1:0]              cpc_z,
    output logic [7:0]                   z_of_m8c,
    output logic [3:0]                   z_of_m16c,
    output logic                         tile_stb,
    output logic                         hi_wrap
`ifdef IKA9958_CPC_LINE_CNT_EN
   ,output logic [9:0]                   line_cnt,
    output logic                         frame_stb
`endif
);

    localparam int DLY_W = $clog2(DLY_MAX+1);

    logic [LO_W-1:0]  lo;
    logic [HI_W-1:0]  hi;
    cpc_mode_e        mode_lat;
    logic [DLY_W-1:0] dly_lat;
    logic [DLY_W-1:0] dly_sat;
    logic [LO_W:0]    tile_last;
    logic             raw_carry;
    logic             carry_app;
    logic             hi_last;
    logic             inc_q;
    logic             wrap_q;
    cpc_modulo_t      mod_d;
    cpc_modulo_t      mod_q;

    assign cpc       = {hi, lo};
    assign cpc_z     = LO_W'(mod_q.z);
    assign z_of_m8c  = mod_q.z_of_m8c;
    assign z_of_m16c = mod_q.z_of_m16c;

    // Tile boundary detect; a line restart suppresses the carry it would have raised.
    always_comb begin
        tile_last = (LO_W+1)'(tile_len(mode_lat, GFX_LEN, TXT_LEN) - 1);
        raw_carry = ({1'b0, lo} >= tile_last) && !line_sync;
        hi_last   = (hi == HI_W'(HI_MOD - 1));
        dly_sat   = (int'(carry_dly) > DLY_MAX) ? DLY_W'(DLY_MAX) : carry_dly;
    end

    ika9958_cpc_carry_dly #(
        .DLY_MAX (DLY_MAX),
        .DLY_W   (DLY_W)
    ) u_carry_dly (
        .phiA        (phiA),
        .RST_async_n (RST_async_n),
        .en          (phiL_NCEN),
        .clr         (line_sync),
        .din         (raw_carry),
        .tap         (dly_lat),
        .dout        (carry_app)
    );

    // Decodes of the current (pre-update) low field; the upper half of a text tile is blanked.
    always_comb begin
        mod_d   = '0;
        mod_d.z = CPC_LO_W'(lo);
        for (int k = 0; k < 8; k++) begin
            mod_d.z_of_m8c[k] = (lo[2:0] == 3'(k)) && !((mode_lat == CPC_MODE_TXT) && lo[3]);
        end
        for (int j = 0; j < 4; j++) begin
            mod_d.z_of_m16c[j] = (lo == LO_W'(8 + j));
        end
    end

    // Counter, line latches and pulse pipeline; tile_stb/hi_wrap trail the hi update by one edge.
    always_ff @(posedge phiA or negedge RST_async_n) begin
        if (!RST_async_n) begin
            lo       <= '0;
            hi       <= '0;
            mode_lat <= CPC_MODE_GFX;
            dly_lat  <= '0;
            inc_q    <= 1'b0;
            wrap_q   <= 1'b0;
            tile_stb <= 1'b0;
            hi_wrap  <= 1'b0;
            mod_q    <= '0;
        end else if (phiL_NCEN) begin
            tile_stb <= inc_q;
            hi_wrap  <= wrap_q;
            mod_q    <= mod_d;
            if (line_sync) begin
                lo       <= LO_W'(LO_LOAD);
                hi       <= HI_W'(HI_LOAD);
                mode_lat <= cpc_mode_e'(mode_txt);
                dly_lat  <= dly_sat;
                inc_q    <= 1'b0;
                wrap_q   <= 1'b0;
            end else begin
                lo     <= raw_carry ? '0 : lo + 1'b1;
                inc_q  <= carry_app;
                wrap_q <= carry_app && hi_last;
                if (carry_app) begin
                    hi <= hi_last ? '0 : hi + 1'b1;
                end
            end
        end
    end

`ifdef IKA9958_CPC_LINE_CNT_EN
    // Line counter advances on every accepted line restart; frame_stb marks its wrap.
    always_ff @(posedge phiA or negedge RST_async_n) begin
        if (!RST_async_n) begin
            line_cnt  <= '0;
            frame_stb <= 1'b0;
        end else if (phiL_NCEN) begin
            frame_stb <= 1'b0;
            if (line_sync) begin
                if (line_cnt == 10'(LINE_MOD - 1)) begin
                    line_cnt  <= '0;
                    frame_stb <= 1'b1;
                end else begin
                    line_cnt <= line_cnt + 1'b1;
                end
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // Parameter sanity check.
    always @(posedge phiA) begin
        assert (GFX_LEN <= (1 << LO_W) && TXT_LEN <= (1 << LO_W) &&
                HI_MOD <= (1 << HI_W) && LO_W == CPC_LO_W)
            else $error("ika9958_cpc_gen: parameter out of range");
    end
`endif

endmodule

// File: tb/tb_ika9958_cpc_gen.sv
// Scoreboard bench for ika9958_cpc_gen (instance built with HI_MOD=5).
module tb_ika9958_cpc_gen;

    localparam int HMOD = 5;

    logic       phiA = 1'b0;
    logic       RST_async_n;
    logic       phiL_NCEN;
    logic       line_sync;
    logic       mode_txt;
    logic [2:0] carry_dly;
    logic [8:0] cpc;
    logic [3:0] cpc_z;
    logic [7:0] z_of_m8c;
    logic [3:0] z_of_m16c;
    logic       tile_stb;
    logic       hi_wrap;
`ifdef IKA9958_CPC_LINE_CNT_EN
    logic [9:0] line_cnt;
    logic       frame_stb;
`endif

    ika9958_cpc_gen #(.HI_MOD(HMOD)) dut (
        .phiA        (phiA),
        .RST_async_n (RST_async_n),
        .phiL_NCEN   (phiL_NCEN),
        .line_sync   (line_sync),
        .mode_txt    (mode_txt),
        .carry_dly   (carry_dly),
        .cpc         (cpc),
        .cpc_z       (cpc_z),
        .z_of_m8c    (z_of_m8c),
        .z_of_m16c   (z_of_m16c),
        .tile_stb    (tile_stb),
        .hi_wrap     (hi_wrap)
`ifdef IKA9958_CPC_LINE_CNT_EN
       ,.line_cnt    (line_cnt),
        .frame_stb   (frame_stb)
`endif
    );

    always #5 phiA = ~phiA;

    typedef struct packed {
        logic [8:0] cpc;
        logic [3:0] z;
        logic [7:0] m8;
        logic [3:0] m16;
        logic       stb;
        logic       wrap;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // reference state
    int   m_lo, m_hi, m_mode, m_dly, m_stb_p, m_wrap_p;
    int   inflight[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        m_lo = 0; m_hi = 0; m_mode = 0; m_dly = 0; m_stb_p = 0; m_wrap_p = 0;
        inflight.delete();
        cur = '0;
    endtask

    // One enabled edge of the reference counter.
    task automatic model_edge(input bit ls, input bit mt, input int cd);
        exp_t n;
        int   len;
        bit   rc, app;
        n   = cur;
        n.z = m_lo[3:0];
        for (int k = 0; k < 8; k++) n.m8[k] = ((m_lo % 8) == k) && !(m_mode == 1 && m_lo >= 8);
        for (int j = 0; j < 4; j++) n.m16[j] = (m_lo == 8 + j);
        n.stb  = m_stb_p[0];
        n.wrap = m_wrap_p[0];
        if (ls) begin
            m_lo = 0; m_hi = 0; m_mode = mt; m_dly = (cd > 7) ? 7 : cd;
            inflight.delete();
            m_stb_p = 0; m_wrap_p = 0;
        end else begin
            len  = m_mode ? 12 : 16;
            rc   = (m_lo >= len - 1);
            m_lo = rc ? 0 : m_lo + 1;
            app  = 0;
            for (int i = 0; i < inflight.size(); i++) inflight[i] = inflight[i] - 1;
            if (inflight.size() > 0 && inflight[0] == 0) begin
                app = 1;
                void'(inflight.pop_front());
            end
            if (rc) begin
                if (m_dly == 0) app = 1;
                else inflight.push_back(m_dly);
            end
            m_stb_p  = app ? 1 : 0;
            m_wrap_p = (app && m_hi == HMOD - 1) ? 1 : 0;
            if (app) m_hi = (m_hi == HMOD - 1) ? 0 : m_hi + 1;
        end
        n.cpc = 9'(m_hi * 16 + m_lo);
        cur   = n;
    endtask

    // Drive one phiA cycle; expected result is queued at the edge.
    task automatic step(input bit en, input bit ls, input bit mt, input int cd);
        phiL_NCEN = en;
        line_sync = ls;
        mode_txt  = mt;
        carry_dly = 3'(cd);
        @(posedge phiA);
        if (en && RST_async_n) model_edge(ls, mt, cd);
        q.push_back(cur);
        #1;
    endtask

    // Assert reset between edges with the enable low, so only the async path can clear state.
    task automatic do_reset();
        @(negedge phiA);
        #1;
        phiL_NCEN   = 1'b0;
        line_sync   = 1'b0;
        RST_async_n = 1'b0;
        model_zero();
        @(posedge phiA);
        q.push_back(cur);
        #3;
        RST_async_n = 1'b1;
    endtask

    // Monitor: compare every presented output against the scoreboard head.
    always @(negedge phiA) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("cpc",       32'(cpc),       32'(mon_e.cpc));
            chk("cpc_z",     32'(cpc_z),     32'(mon_e.z));
            chk("z_of_m8c",  32'(z_of_m8c),  32'(mon_e.m8));
            chk("z_of_m16c", 32'(z_of_m16c), 32'(mon_e.m16));
            chk("tile_stb",  32'(tile_stb),  32'(mon_e.stb));
            chk("hi_wrap",   32'(hi_wrap),   32'(mon_e.wrap));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_async_n = 1'b0;
        phiL_NCEN   = 1'b0;
        line_sync   = 1'b0;
        mode_txt    = 1'b0;
        carry_dly   = 3'd0;
        model_zero();
        @(posedge phiA); q.push_back(cur); #1;
        @(posedge phiA); q.push_back(cur); #2;
        RST_async_n = 1'b1;

        // count into the line, then reset mid-count (cpc=0x027)
        step(1, 1, 0, 0);
        repeat (39) step(1, 0, 0, 0);
        do_reset();
        repeat (3) step(1, 0, 0, 0);

        // graphics tile, no carry delay
        step(1, 1, 0, 0);
        repeat (20) step(1, 0, 0, 0);

        // text requested mid-line has no effect until line_sync
        repeat (5) step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        repeat (30) step(1, 0, 1, 0);

        // carry delayed by 4 enabled edges
        step(1, 1, 1, 4);
        repeat (30) step(1, 0, 1, 0);

        // line_sync 2 edges after a wrap drops the pending carry
        step(1, 1, 1, 4);
        repeat (13) step(1, 0, 1, 0);
        step(1, 1, 1, 4);
        repeat (10) step(1, 0, 1, 0);

        // short and maximal delays
        step(1, 1, 0, 1);
        repeat (40) step(1, 0, 0, 0);
        step(1, 1, 0, 7);
        repeat (40) step(1, 0, 0, 0);

        // tile field wrap with the enable toggling every other cycle
        step(1, 1, 0, 0);
        repeat (84) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
        end
        repeat (3) step(1, 0, 0, 0);

        // line_sync coincident with a lo wrap
        step(1, 1, 0, 0);
        repeat (15) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0);

        @(negedge phiA);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
